// File: rtl/seq_gen_multi.sv
// Multi-mode sequence generator (Fibonacci, triangular, squares) stepping at a
// programmable rate, with sticky overflow hold, term index and value parity.
module seq_gen_multi #(
  parameter int WIDTH    = 16,
  parameter int PROG_W   = 3,
  parameter int DIV_BASE = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_f,
  input  logic              start_t,
  input  logic              start_s,
  input  logic              stop,
  input  logic              update,
  input  logic [PROG_W-1:0] prog,
  output logic [WIDTH-1:0]  value,
  output logic              parity,
  output logic [1:0]        mode,
  output logic              running,
  output logic              overflow,
  output logic [WIDTH-1:0]  term_idx
);

  localparam int PMAX  = (2 ** PROG_W) * DIV_BASE;
  localparam int DIV_W = (PMAX > 1) ? $clog2(PMAX) : 1;

  typedef enum logic [2:0] {S_IDLE, S_FIB, S_TRI, S_SQR, S_OVF} state_t;

  // Terminal count of the divider for a given speed word: (s+1)*DIV_BASE - 1.
  function automatic logic [DIV_W-1:0] term_count(input logic [PROG_W-1:0] s);
    int p;
    p = (int'(s) + 1) * DIV_BASE - 1;
    return p[DIV_W-1:0];
  endfunction

  state_t            state;
  logic [PROG_W-1:0] spd;
  logic [PROG_W-1:0] spd_nxt;
  logic [DIV_W-1:0]  div;
  logic [DIV_W-1:0]  tc;
  logic [WIDTH-1:0]  a;
  logic [WIDTH:0]    b;
  logic [WIDTH-1:0]  n;
  logic [WIDTH+1:0]  nxt_term;
  logic              wrap;
  logic              step_ovf;
  logic              any_start;

  always_comb begin
    spd_nxt   = update ? prog : spd;
    wrap      = (div == tc);
    any_start = start_f | start_t | start_s;
    nxt_term  = '0;
    case (state)
      S_FIB:   nxt_term = {1'b0, b};
      S_TRI:   nxt_term = {2'b00, value} + {2'b00, n} + (WIDTH+2)'(1);
      // 2*term_idx+1 is just term_idx with a 1 shifted in.
      S_SQR:   nxt_term = {2'b00, value} + {1'b0, term_idx, 1'b1};
      default: nxt_term = '0;
    endcase
    step_ovf = |nxt_term[WIDTH+1:WIDTH];
  end

  assign parity = ^value;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      mode     <= 2'd0;
      running  <= 1'b0;
      overflow <= 1'b0;
      value    <= '0;
      term_idx <= '0;
      spd      <= '0;
      div      <= '0;
      tc       <= term_count('0);
      a        <= '0;
      b        <= '0;
      n        <= '0;
    end else begin
      if (update)
        spd <= prog;

      if (stop) begin
        state   <= S_IDLE;
        mode    <= 2'd0;
        running <= 1'b0;
        div     <= '0;
      end else if (any_start) begin
        if (start_f) begin
          state <= S_FIB;
          mode  <= 2'd1;
        end else if (start_t) begin
          state <= S_TRI;
          mode  <= 2'd2;
        end else begin
          state <= S_SQR;
          mode  <= 2'd3;
        end
        running  <= 1'b1;
        overflow <= 1'b0;
        value    <= '0;
        term_idx <= '0;
        div      <= '0;
        tc       <= term_count(spd_nxt);
        a        <= '0;
        b        <= (WIDTH+1)'(1);
        n        <= '0;
      end else if (state == S_FIB || state == S_TRI || state == S_SQR) begin
        if (wrap) begin
          div <= '0;
          // A speed change only takes hold at a period boundary.
          tc  <= term_count(spd_nxt);
          if (step_ovf) begin
            state    <= S_OVF;
            running  <= 1'b0;
            overflow <= 1'b1;
          end else begin
            value    <= nxt_term[WIDTH-1:0];
            term_idx <= term_idx + WIDTH'(1);
            if (state == S_FIB) begin
              a <= b[WIDTH-1:0];
              b <= {1'b0, a} + b;
            end
            if (state == S_TRI)
              n <= n + WIDTH'(1);
          end
        end else begin
          div <= div + DIV_W'(1);
        end
      end
    end
  end

endmodule
